// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor. The carry chain is split into
// STAGES = WIDTH/CHUNK ripple segments with one register level per segment.
// Operand bits that are not yet used and sum bits that are already finished
// move along in skew registers next to the segment carry. A valid/ready
// handshake stalls every stage together when the output is not accepted.
module pipelined_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  if ((WIDTH < 2) || (CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("pipelined_addsub: WIDTH must be >= 2 and an integer multiple of CHUNK");
  end

  // Element k holds the inputs of stage k. Element STAGES holds the pipe output.
  logic [WIDTH-1:0] w_a [STAGES];
  logic [WIDTH-1:0] w_b [STAGES];
  logic [WIDTH-1:0] w_s [STAGES+1];
  logic             w_c [STAGES+1];
  logic             w_v [STAGES+1];
  logic             w_stall;
  logic             r_cm;

  assign w_stall  = w_v[STAGES] & ~out_ready;
  assign in_ready = ~w_stall;

  // Subtraction uses a + ~b + ~cin. Stage 0 starts from the conditioned operands.
  assign w_a[0] = a;
  assign w_b[0] = sub ? ~b : b;
  assign w_c[0] = sub ? ~cin : cin;
  assign w_s[0] = '0;
  assign w_v[0] = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * CHUNK;

    logic [CHUNK:0]   w_chunk;
    logic [WIDTH-1:0] w_s_nxt;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_v;

    assign w_chunk = {1'b0, w_a[k][LO +: CHUNK]} + {1'b0, w_b[k][LO +: CHUNK]}
                   + {{CHUNK{1'b0}}, w_c[k]};

    // Insert this segment's sum bits into the partial result passed down the pipe
    always_comb begin
      w_s_nxt = w_s[k];
      w_s_nxt[LO +: CHUNK] = w_chunk[CHUNK-1:0];
    end

    // Segment result, carry and valid register; holds while the output stalls
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= 1'b0;
        r_s <= '0;
        r_c <= 1'b0;
      end else if (!w_stall) begin
        r_v <= w_v[k];
        r_s <= w_s_nxt;
        r_c <= w_chunk[CHUNK];
      end
    end

    assign w_v[k+1] = r_v;
    assign w_s[k+1] = r_s;
    assign w_c[k+1] = r_c;

    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;

      // Carry the operands forward for the segments that are not yet processed
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (!w_stall) begin
          r_a <= w_a[k];
          r_b <= w_b[k];
        end
      end

      assign w_a[k+1] = r_a;
      assign w_b[k+1] = r_b;
    end else begin : g_last
      // Carry into the MSB is recovered as sum ^ a ^ b at that bit. That saves
      // keeping the operands in the final register level just for overflow.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cm <= 1'b0;
        end else if (!w_stall) begin
          r_cm <= w_chunk[CHUNK-1] ^ w_a[k][WIDTH-1] ^ w_b[k][WIDTH-1];
        end
      end
    end
  end

  assign out_valid = w_v[STAGES];
  assign sum       = w_s[STAGES];
  assign cout      = w_c[STAGES];
  assign ovf       = w_c[STAGES] ^ r_cm;

endmodule
